// File: rtl/ddr3_pg_ring_sched_if.sv
// Signal bundle between the page-ring scheduler and its environment.
// The master modport is the scheduler. The slave modport covers the producer,
// the consumer, the DDR3 page-transfer controller and the status observers.
interface ddr3_pg_ring_sched_if #(
    parameter int unsigned N_PAGES_W = 12
);
    logic                 wr_pg_req;
    logic                 wr_pg_ack;
    logic                 rd_pg_req;
    logic                 rd_pg_ack;
    logic                 pg_req;
    logic                 pg_optype;
    logic [27:0]          pg_req_addr;
    logic                 pg_ack;
    logic [N_PAGES_W:0]   n_pages_used;
    logic                 empty;
    logic                 full;
    logic                 busy;
    logic [15:0]          ovfl_cnt;

    modport master (
        input  wr_pg_req,
        input  rd_pg_req,
        input  pg_ack,
        output wr_pg_ack,
        output rd_pg_ack,
        output pg_req,
        output pg_optype,
        output pg_req_addr,
        output n_pages_used,
        output empty,
        output full,
        output busy,
        output ovfl_cnt
    );

    modport slave (
        output wr_pg_req,
        output rd_pg_req,
        output pg_ack,
        input  wr_pg_ack,
        input  rd_pg_ack,
        input  pg_req,
        input  pg_optype,
        input  pg_req_addr,
        input  n_pages_used,
        input  empty,
        input  full,
        input  busy,
        input  ovfl_cnt
    );
endinterface

// File: rtl/ddr3_pg_ring_sched.sv
// Page-ring scheduler for the DDR3 page-transfer controller.
// DDR3 is treated as a circular buffer of fixed-size pages. A producer stores
// pages into it and a consumer fetches pages out of it. Both clients share one
// four-phase pg_req/pg_ack handshake to the controller.
// Write grants normally win. A pending read is forced through after
// RD_STARVE_MAX write grants in a row that passed it over.
// Optional feature macro: PG_RING_OVERWRITE_EN. When it is defined, a write to
// a full ring overwrites the oldest page and ovfl_cnt counts these overwrites.
module ddr3_pg_ring_sched #(
    parameter logic [27:0] BASE_ADDR      = 28'h0000000,
    parameter int unsigned PG_ADDR_STRIDE = 2048,
    parameter int unsigned N_PAGES_W      = 12,
    parameter int unsigned RD_STARVE_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ddr3_pg_ring_sched_if.master   pg_bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_CLIENT_ACK
    } state_t;

    localparam int unsigned        STARVE_W   = (RD_STARVE_MAX < 1) ? 1 : $clog2(RD_STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(RD_STARVE_MAX);
    localparam logic [N_PAGES_W:0] FULL_COUNT = {1'b1, {N_PAGES_W{1'b0}}};
    localparam logic [27:0]        STRIDE     = 28'(PG_ADDR_STRIDE);

    state_t                 r_state;
    logic                   r_isWrite;
    logic [N_PAGES_W-1:0]   r_wrPtr;
    logic [N_PAGES_W-1:0]   r_rdPtr;
    logic [N_PAGES_W:0]     r_count;
    logic [STARVE_W-1:0]    r_starve;
    logic                   r_empty;
    logic                   r_full;
    logic                   r_pgReq;
    logic                   r_pgOptype;
    logic [27:0]            r_pgAddr;
    logic                   r_wrAck;
    logic                   r_rdAck;
`ifdef PG_RING_OVERWRITE_EN
    logic [15:0]            r_ovflCnt;
`endif

    logic                   w_wrElig;
    logic                   w_rdElig;
    logic                   w_grantWr;
    logic                   w_grantRd;
    logic                   w_clientReq;
    logic [27:0]            w_wrAddr;
    logic [27:0]            w_rdAddr;
    logic [N_PAGES_W:0]     w_countInc;
    logic [N_PAGES_W:0]     w_countDec;

    // Eligibility. In overwrite mode a full ring does not block the producer.
`ifdef PG_RING_OVERWRITE_EN
    assign w_wrElig = pg_bus.wr_pg_req;
`else
    assign w_wrElig = pg_bus.wr_pg_req & ~r_full;
`endif
    assign w_rdElig = pg_bus.rd_pg_req & ~r_empty;

    // Arbitration. Writes win unless the read has been passed over too often.
    assign w_grantRd = w_rdElig & (~w_wrElig | (r_starve >= STARVE_MAX));
    assign w_grantWr = w_wrElig & ~w_grantRd;

    // Page start addresses. The result wraps modulo the 28-bit app address space.
    assign w_wrAddr = BASE_ADDR + (28'(r_wrPtr) * STRIDE);
    assign w_rdAddr = BASE_ADDR + (28'(r_rdPtr) * STRIDE);

    assign w_countInc  = r_count + 1'b1;
    assign w_countDec  = r_count - 1'b1;
    assign w_clientReq = r_isWrite ? pg_bus.wr_pg_req : pg_bus.rd_pg_req;

    // Transfer FSM. It also holds the ring pointers, the fill count and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_isWrite  <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_pgReq    <= 1'b0;
            r_pgOptype <= 1'b0;
            r_pgAddr   <= '0;
            r_wrAck    <= 1'b0;
            r_rdAck    <= 1'b0;
`ifdef PG_RING_OVERWRITE_EN
            r_ovflCnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantWr) begin
                        r_isWrite  <= 1'b1;
                        r_pgOptype <= 1'b1;
                        r_pgAddr   <= w_wrAddr;
                        r_pgReq    <= 1'b1;
                        r_state    <= S_ISSUE;
                        if (w_rdElig && (r_starve < STARVE_MAX)) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end else if (w_grantRd) begin
                        r_isWrite  <= 1'b0;
                        r_pgOptype <= 1'b0;
                        r_pgAddr   <= w_rdAddr;
                        r_pgReq    <= 1'b1;
                        r_starve   <= '0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pg_bus.pg_ack) begin
                        r_pgReq <= 1'b0;
                        r_state <= S_RELEASE;
                        if (r_isWrite) begin
                            r_wrPtr <= r_wrPtr + 1'b1;
`ifdef PG_RING_OVERWRITE_EN
                            if (r_full) begin
                                r_rdPtr <= r_rdPtr + 1'b1;
                                if (r_ovflCnt != 16'hFFFF) begin
                                    r_ovflCnt <= r_ovflCnt + 1'b1;
                                end
                            end else begin
                                r_count <= w_countInc;
                                r_empty <= 1'b0;
                                r_full  <= (w_countInc == FULL_COUNT);
                            end
`else
                            r_count <= w_countInc;
                            r_empty <= 1'b0;
                            r_full  <= (w_countInc == FULL_COUNT);
`endif
                        end else begin
                            r_rdPtr <= r_rdPtr + 1'b1;
                            r_count <= w_countDec;
                            r_empty <= (w_countDec == '0);
                            r_full  <= 1'b0;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!pg_bus.pg_ack) begin
                        if (r_isWrite) begin
                            r_wrAck <= 1'b1;
                        end else begin
                            r_rdAck <= 1'b1;
                        end
                        r_state <= S_CLIENT_ACK;
                    end
                end
                S_CLIENT_ACK: begin
                    if (!w_clientReq) begin
                        r_wrAck <= 1'b0;
                        r_rdAck <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pg_bus.pg_req       = r_pgReq;
    assign pg_bus.pg_optype    = r_pgOptype;
    assign pg_bus.pg_req_addr  = r_pgAddr;
    assign pg_bus.wr_pg_ack    = r_wrAck;
    assign pg_bus.rd_pg_ack    = r_rdAck;
    assign pg_bus.n_pages_used = r_count;
    assign pg_bus.empty        = r_empty;
    assign pg_bus.full         = r_full;
    assign pg_bus.busy         = (r_state != S_IDLE);
`ifdef PG_RING_OVERWRITE_EN
    assign pg_bus.ovfl_cnt     = r_ovflCnt;
`else
    assign pg_bus.ovfl_cnt     = 16'd0;
`endif

endmodule

// File: doc/ddr3_pg_ring_sched.md
Name: ddr3_pg_ring_sched

Overview:
- Schedules page transfers between two clients and the single DDR3 page-transfer controller.
- Producer: waveform writer storing full DPRAM pages. Consumer: readout fetching pages.
- DDR3 is managed as a circular buffer of fixed-size pages. The block owns the write/read page pointers, the fill count and full/empty status.
- It serializes both clients onto one four-phase pg_req/pg_ack handshake.

Parameters:
- BASE_ADDR, 28'h0000000, DDR3 app address of page 0.
- PG_ADDR_STRIDE, 2048, app-address units per page (256 bursts x 8).
- N_PAGES_W, 12, log2 of ring size in pages (4096 pages).
- RD_STARVE_MAX, 4, consecutive write grants with an eligible read pending before read gets priority.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wr_pg_req  in  1  producer request: DPRAM page ready to store
- wr_pg_ack  out  1  producer ack: page stored
- rd_pg_req  in  1  consumer request: fetch next page into DPRAM
- rd_pg_ack  out  1  consumer ack: page fetched
- pg_req  out  1  request to page-transfer controller
- pg_optype  out  1  0 = read DDR3->DPRAM, 1 = write DPRAM->DDR3
- pg_req_addr  out  28  page start app address
- pg_ack  in  1  controller ack
- n_pages_used  out  N_PAGES_W+1  pages currently stored
- empty  out  1  n_pages_used == 0
- full  out  1  n_pages_used == 2**N_PAGES_W
- busy  out  1  FSM not in S_IDLE
- ovfl_cnt  out  16  overwritten-page count (see Optional Feature)

Behaviour:
- Reset (async):
  - All outputs 0, except empty = 1.
  - wr_ptr, rd_ptr, count, starve_cnt = 0; FSM = S_IDLE.
  - Reset mid-transfer drops pg_req immediately. The downstream controller shares the reset.
- Client handshake is four-phase:
  - Client raises req and holds it.
  - Block raises ack after the DDR3 transfer completes.
  - Client drops req; block drops ack on the next cycle.
  - Requests are sampled only in S_IDLE. Once granted, a transaction completes even if the client drops req early; ack is then pulsed for one cycle.
- Eligibility in S_IDLE:
  - wr_elig = wr_pg_req & ~full
  - rd_elig = rd_pg_req & ~empty
- Arbitration:
  - Only wr_elig: grant write. Only rd_elig: grant read.
  - Both: grant read if starve_cnt >= RD_STARVE_MAX, else grant write.
  - starve_cnt increments (saturating at RD_STARVE_MAX) on a write grant while rd_elig. It clears on any read grant.
- On grant (registered):
  - pg_optype = 1 for write, 0 for read.
  - pg_req_addr = BASE_ADDR + ptr*PG_ADDR_STRIDE (wr_ptr or rd_ptr), truncated to 28 bits.
  - pg_req = 1 the cycle after the grant decision; go to S_ISSUE.
- S_ISSUE: hold pg_req/pg_optype/pg_req_addr stable until pg_ack = 1. On that cycle:
  - drop pg_req
  - update pointers: write -> wr_ptr+1, count+1; read -> rd_ptr+1, count-1
  - go to S_RELEASE
- Pointer arithmetic:
  - Pointers are N_PAGES_W bits and wrap naturally (4095 -> 0).
  - count is N_PAGES_W+1 bits, never exceeds 2**N_PAGES_W, never underflows.
- S_RELEASE: wait for pg_ack = 0, then raise the granted client's ack; go to S_CLIENT_ACK.
- S_CLIENT_ACK: hold client ack until that client's req = 0; drop ack next cycle; return to S_IDLE.
- Minimum idle-to-idle with zero-latency peers: 5 cycles.
- empty/full/n_pages_used are registered and reflect the count after the update cycle.
- busy = (FSM != S_IDLE).

Optional Feature:
- Macro: PG_RING_OVERWRITE_EN.
- Defined:
  - wr_elig = wr_pg_req regardless of full.
  - A write granted while full stores to wr_ptr (== rd_ptr). On pg_ack, wr_ptr and rd_ptr both advance, count is unchanged, and ovfl_cnt increments, saturating at 16'hFFFF. The oldest page is discarded.
- Undefined:
  - Writes stall while full.
  - ovfl_cnt is tied to 0.

Test Plan:
- Reset, single write request, controller acks after 10 cycles:
  - pg_req asserted with pg_optype = 1, pg_req_addr = 0.
  - wr_pg_ack asserted after pg_ack falls.
  - n_pages_used = 1, empty = 0.
- Read request while empty:
  - No pg_req for 100 cycles, rd_pg_ack = 0.
  - Then issue a write; after it completes, the read proceeds with pg_req_addr = 0, pg_optype = 0, and empty = 1 afterwards.
- Three writes then a read, N_PAGES_W = 2, BASE_ADDR = 28'h100:
  - Write addresses 0x100, 0x900, 0x1100.
  - Read address 0x100.
  - n_pages_used = 2.
- Wrap and full, N_PAGES_W = 2:
  - 4 writes -> full = 1; a 5th write stalls.
  - 1 read -> 5th write completes at address 0x0; wr_ptr has wrapped.
- Continuous wr_pg_req and rd_pg_req with RD_STARVE_MAX = 4, count > 0:
  - Grant pattern W,W,W,W,R repeating.
  - starve_cnt clears after each R.
- With PG_RING_OVERWRITE_EN, N_PAGES_W = 2:
  - 5 writes: ovfl_cnt = 1, n_pages_used = 4.
  - Next read address = page 1 (BASE_ADDR + 2048).
  - Also assert rst during S_ISSUE -> pg_req = 0 immediately, all counters 0.
